// File: rtl/pkt_receiver_if.sv
// NoC-egress and frame-side signal bundle for pkt_receiver.
// master: the NoC source plus frame consumer (bench side); slave: the receiver.
interface pkt_receiver_if #(
   parameter int unsigned AVL_DATA_WIDTH = 512,
   parameter int unsigned FRAME_ID_WIDTH = 32
);
   localparam int unsigned WIDTH_PKT = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH;

   logic [WIDTH_PKT-1:0]      noc_data_out;
   logic [3:0]                noc_valid_out;
   logic [3:0]                noc_sop_out;
   logic [3:0]                noc_eop_out;
   logic                      noc_ready_in;
   logic                      frame_valid;
   logic                      frame_ready;
   logic                      frame_write;
   logic                      frame_read;
   logic [FRAME_ID_WIDTH-1:0] frame_id;
   logic [AVL_DATA_WIDTH-1:0] frame_data;
   logic                      frame_sop;
   logic                      frame_eop;

   modport master (
      output noc_data_out, noc_valid_out, noc_sop_out, noc_eop_out, frame_ready,
      input  noc_ready_in, frame_valid, frame_write, frame_read, frame_id, frame_data,
             frame_sop, frame_eop
   );

   modport slave (
      input  noc_data_out, noc_valid_out, noc_sop_out, noc_eop_out, frame_ready,
      output noc_ready_in, frame_valid, frame_write, frame_read, frame_id, frame_data,
             frame_sop, frame_eop
   );
endinterface

// File: rtl/pkt_receiver.sv
// NoC-egress packet sink: checks framing, keeps sticky error codes and counters, and buffers
// accepted beats in a small FIFO for the frame-side consumer.
// Optional build macro PKT_RECEIVER_DATA_CHECK_EN adds the in-packet payload increment check.
module pkt_receiver #(
   parameter int unsigned AVL_DATA_WIDTH = 512,
   parameter int unsigned FRAME_ID_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned MAX_BEATS      = 16
) (
   input  logic          clk,
   input  logic          rst,
   pkt_receiver_if.slave bus,
   output logic [15:0]   pkt_count,
   output logic [15:0]   err_count,
   output logic [4:0]    err_code
);
   localparam int unsigned WIDTH_PKT = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH;
   localparam int unsigned ENTRY_W   = WIDTH_PKT + 2;
   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 2);

   typedef enum logic [0:0] {StIdle, StInPkt} state_e;

   state_e                    state_q, state_d;
   logic [FRAME_ID_WIDTH-1:0] id_q, id_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [15:0]               pkt_count_q, pkt_count_d;
   logic [15:0]               err_count_q, err_count_d;
   logic [4:0]                err_code_q, err_code_d;
   logic [ENTRY_W-1:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]          occ_q, occ_d;
   logic                      ready_q, ready_d;

   logic                      accept, push, pop, drop, pkt_done;
   logic [4:0]                err_set;
   logic                      beat_sop, beat_eop, beat_write, beat_read;
   logic [FRAME_ID_WIDTH-1:0] beat_id;
   logic [AVL_DATA_WIDTH-1:0] beat_data;
   logic [ENTRY_W-1:0]        head;
   logic                      unused_ctrl;

   // Only valid[0], sop[0] and eop[3] carry meaning; the other replicas are ignored.
   assign unused_ctrl = ^{bus.noc_valid_out[3:1], bus.noc_sop_out[3:1], bus.noc_eop_out[2:0]};

   assign beat_sop   = bus.noc_sop_out[0];
   assign beat_eop   = bus.noc_eop_out[3];
   assign beat_write = bus.noc_data_out[WIDTH_PKT-1];
   assign beat_read  = bus.noc_data_out[WIDTH_PKT-2];
   assign beat_id    = bus.noc_data_out[WIDTH_PKT-3 -: FRAME_ID_WIDTH];
   assign beat_data  = bus.noc_data_out[AVL_DATA_WIDTH-1:0];

   assign accept = bus.noc_valid_out[0] & ready_q;
   assign push   = accept & ~drop;
   assign pop    = bus.frame_valid & bus.frame_ready;

`ifdef PKT_RECEIVER_DATA_CHECK_EN
   logic [AVL_DATA_WIDTH-1:0] prev_data_q, prev_data_d;
   logic                      data_err;

   // Payload must step by one across non-sop write beats of a packet.
   always_comb begin
      prev_data_d = prev_data_q;
      data_err    = 1'b0;
      if (accept && !drop) begin
         prev_data_d = beat_data;
         if (state_q == StInPkt && !beat_sop && !beat_read &&
             beat_data != prev_data_q + AVL_DATA_WIDTH'(1)) begin
            data_err = 1'b1;
         end
      end
   end

   // Previous-payload register for the increment check.
   always_ff @(posedge clk) begin
      if (!rst) prev_data_q <= '0;
      else      prev_data_q <= prev_data_d;
   end
`else
   logic data_err;
   assign data_err = 1'b0;
`endif

   // Framing FSM plus sticky error and counter next-state.
   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      pkt_count_d = pkt_count_q;
      err_count_d = err_count_q;
      err_set     = '0;
      drop        = 1'b0;
      pkt_done    = 1'b0;
      if (accept) begin
         err_set[3] = beat_write & beat_read;
         err_set[4] = data_err;
         unique case (state_q)
            StIdle: begin
               if (!beat_sop) begin
                  err_set[0] = 1'b1;
                  drop       = 1'b1;
               end else begin
                  id_d     = beat_id;
                  cnt_d    = CNT_W'(1);
                  state_d  = beat_eop ? StIdle : StInPkt;
                  pkt_done = beat_eop;
               end
            end
            StInPkt: begin
               if (beat_sop) begin
                  // Restart on an unexpected sop: the new packet owns the stream from here.
                  err_set[1] = 1'b1;
                  id_d       = beat_id;
                  cnt_d      = CNT_W'(1);
                  state_d    = beat_eop ? StIdle : StInPkt;
                  pkt_done   = beat_eop;
               end else begin
                  err_set[2] = (beat_id != id_q);
                  if (cnt_q >= CNT_W'(MAX_BEATS)) begin
                     err_set[3] = 1'b1;
                     state_d    = StIdle;
                  end else begin
                     cnt_d    = cnt_q + CNT_W'(1);
                     state_d  = beat_eop ? StIdle : StInPkt;
                     pkt_done = beat_eop;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
      if (pkt_done) pkt_count_d = pkt_count_q + 16'd1;
      if ((|err_set) && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
      err_code_d = err_code_q | err_set;
   end

   // FIFO pointer/occupancy next-state; ready looks one cycle ahead so the FIFO never overflows.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
      ready_d  = (occ_d < OCC_W'(FIFO_DEPTH));
   end

   // Control state; synchronous reset discards any partial packet.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         id_q        <= '0;
         cnt_q       <= '0;
         pkt_count_q <= '0;
         err_count_q <= '0;
         err_code_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         pkt_count_q <= pkt_count_d;
         err_count_q <= err_count_d;
         err_code_q  <= err_code_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         ready_q     <= ready_d;
      end
   end

   // Beat storage; contents need no reset because the head is masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {beat_sop, beat_eop, bus.noc_data_out};
   end

   // Head outputs are forced to zero when the FIFO is empty.
   always_comb begin
      head = mem_q[rd_ptr_q] & {ENTRY_W{bus.frame_valid}};
   end

   assign bus.frame_valid  = (occ_q != '0);
   assign bus.frame_sop    = head[ENTRY_W-1];
   assign bus.frame_eop    = head[ENTRY_W-2];
   assign bus.frame_write  = head[WIDTH_PKT-1];
   assign bus.frame_read   = head[WIDTH_PKT-2];
   assign bus.frame_id     = head[WIDTH_PKT-3 -: FRAME_ID_WIDTH];
   assign bus.frame_data   = head[AVL_DATA_WIDTH-1:0];
   assign bus.noc_ready_in = ready_q;
   assign pkt_count        = pkt_count_q;
   assign err_count        = err_count_q;
   assign err_code         = err_code_q;
endmodule
